// File: rtl/spi_master_arbiter_if.sv
// Bus bundle between the requesters/SPI master and spi_master_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_master_arbiter_if #(
  parameter int unsigned PACK_LENGTH = 8,
  parameter int unsigned NUM_REQ     = 4
);
  logic [NUM_REQ-1:0]             IN_REQ;
  logic [NUM_REQ*PACK_LENGTH-1:0] IN_REQ_DATA;
  logic [NUM_REQ-1:0]             OUT_GRANT;
  logic [NUM_REQ-1:0]             OUT_ACK;
  logic [PACK_LENGTH-1:0]         OUT_RESP_DATA;
  logic                           OUT_TIMEOUT;
  logic                           OUT_BUSY;
  logic                           OUT_LAUNCH;
  logic [PACK_LENGTH-1:0]         OUT_MASTER_DATA;
  logic                           IN_MASTER_CS;
  logic [PACK_LENGTH-1:0]         IN_MASTER_RECEIVE_DATA;
  logic                           IN_MASTER_ACTION_DONE;

  modport master (
    input  IN_REQ, IN_REQ_DATA, IN_MASTER_CS, IN_MASTER_RECEIVE_DATA,
           IN_MASTER_ACTION_DONE,
    output OUT_GRANT, OUT_ACK, OUT_RESP_DATA, OUT_TIMEOUT, OUT_BUSY,
           OUT_LAUNCH, OUT_MASTER_DATA
  );

  modport slave (
    output IN_REQ, IN_REQ_DATA, IN_MASTER_CS, IN_MASTER_RECEIVE_DATA,
           IN_MASTER_ACTION_DONE,
    input  OUT_GRANT, OUT_ACK, OUT_RESP_DATA, OUT_TIMEOUT, OUT_BUSY,
           OUT_LAUNCH, OUT_MASTER_DATA
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Grants one owner, launches the frame, waits for the master's done edge
// (or a timeout) and returns the received frame with a one-cycle ACK.
module spi_master_arbiter #(
  parameter int unsigned PACK_LENGTH        = 8,
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned LAUNCH_HOLD_CYCLES = 5,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic               IN_CLOCK,
  input  logic               IN_RESET,
  spi_master_arbiter_if.master bus
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned HCNT_W = (LAUNCH_HOLD_CYCLES > 0) ? $clog2(LAUNCH_HOLD_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(LAUNCH_HOLD_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_HOLD,
    ST_XFER,
    ST_COMPLETE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   timeout_q, timeout_d;
  logic                   launch_q, launch_d;
  logic [PACK_LENGTH-1:0] mdata_q, mdata_d;
  logic [PACK_LENGTH-1:0] resp_q, resp_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic                   done_q, done_d;

  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   done_rise;
  logic                   expired;

  // Round-robin pick: first requester at or after last_grant+1, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!found && bus.IN_REQ[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    timeout_d = 1'b0;
    launch_d  = launch_q;
    mdata_d   = mdata_q;
    resp_d    = resp_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    hcnt_d    = hcnt_q;
    done_d    = bus.IN_MASTER_ACTION_DONE;
    done_rise = bus.IN_MASTER_ACTION_DONE & ~done_q;
    expired   = (tcnt_q == TCNT_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (found && bus.IN_MASTER_CS) begin
          state_d         = ST_LAUNCH;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          mdata_d         = bus.IN_REQ_DATA[32'(winner)*PACK_LENGTH +: PACK_LENGTH];
          launch_d        = 1'b1;
          last_d          = winner;
          tcnt_d          = '0;
        end
      end

      ST_LAUNCH: begin
        if (expired) begin
          state_d   = ST_COMPLETE;
          launch_d  = 1'b0;
          grant_d   = '0;
          ack_d     = grant_q;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (!bus.IN_MASTER_CS) begin
            state_d = ST_HOLD;
            hcnt_d  = HOLD_LOAD;
          end
        end
      end

      // A done edge outranks a coincident timeout, so it is tested first.
      ST_HOLD, ST_XFER: begin
        if (done_rise) begin
          state_d  = ST_COMPLETE;
          launch_d = 1'b0;
          grant_d  = '0;
          ack_d    = grant_q;
          resp_d   = bus.IN_MASTER_RECEIVE_DATA;
        end else if (expired) begin
          state_d   = ST_COMPLETE;
          launch_d  = 1'b0;
          grant_d   = '0;
          ack_d     = grant_q;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (state_q == ST_HOLD) begin
            if (hcnt_q <= HCNT_W'(1)) begin
              state_d  = ST_XFER;
              launch_d = 1'b0;
            end else begin
              hcnt_d = hcnt_q - 1'b1;
            end
          end
        end
      end

      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      launch_q  <= 1'b0;
      mdata_q   <= '0;
      resp_q    <= '0;
      last_q    <= LAST_RST;
      tcnt_q    <= '0;
      hcnt_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      launch_q  <= launch_d;
      mdata_q   <= mdata_d;
      resp_q    <= resp_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      hcnt_q    <= hcnt_d;
      done_q    <= done_d;
    end
  end

  assign bus.OUT_GRANT       = grant_q;
  assign bus.OUT_ACK         = ack_q;
  assign bus.OUT_TIMEOUT     = timeout_q;
  assign bus.OUT_LAUNCH      = launch_q;
  assign bus.OUT_MASTER_DATA = mdata_q;
  assign bus.OUT_RESP_DATA   = resp_q;
  assign bus.OUT_BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed scenarios plus randomized traffic,
// each checked against a transaction-level reference model.
module tb_spi_master_arbiter;

  localparam int NR = 4;
  localparam int PL = 8;
  localparam int H  = 5;
  localparam int T  = 64;

  logic clk;
  logic rst;

  spi_master_arbiter_if #(.PACK_LENGTH(PL), .NUM_REQ(NR)) bus ();

  spi_master_arbiter #(
    .PACK_LENGTH       (PL),
    .NUM_REQ           (NR),
    .LAUNCH_HOLD_CYCLES(H),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .IN_CLOCK(clk),
    .IN_RESET(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         model_last;
  logic [7:0] model_resp;

  // Expected values for one transaction
  logic [3:0] e_grant;
  logic [7:0] e_md;
  logic [7:0] e_resp;
  logic       e_to;
  int         e_ack_c;
  int         e_lcnt;

  // Observed values for one transaction
  logic [3:0] o_grant, o_ack, o_ack_after;
  logic [7:0] o_md0, o_md_end, o_resp;
  logic       o_launch0, o_busy0, o_to, o_launch_ack, o_busy_after;
  int         o_ack_c, o_lcnt;

  function automatic int rr_pick(input logic [3:0] req);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (model_last + k) % NR;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Predict a transaction: owner, frame, when ACK appears, abort or not.
  function automatic void model_txn(input logic [3:0] req, input logic [31:0] data,
                                    input logic [7:0] rx, input int cs_lat, input int done_lat);
    int w;
    w          = rr_pick(req);
    model_last = w;
    e_grant    = 4'(1 << w);
    e_md       = data[w*8 +: 8];
    if (cs_lat >= 0 && done_lat >= 1 && cs_lat + done_lat + 1 <= T) begin
      e_ack_c    = cs_lat + done_lat + 1;
      e_to       = 1'b0;
      model_resp = rx;
    end else begin
      e_ack_c = T;
      e_to    = 1'b1;
    end
    e_resp = model_resp;
    if (cs_lat < 0) e_lcnt = e_ack_c - 1;
    else            e_lcnt = (H < e_ack_c - cs_lat - 1) ? H : e_ack_c - cs_lat - 1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.IN_REQ = '0;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = NR - 1;
    model_resp = '0;
  endtask

  // Drive one transaction as requester + SPI master and record what happened.
  // cs_lat < 0 means CS never falls; done rises done_lat cycles after CS falls.
  task automatic do_txn(input logic [3:0] req, input logic [31:0] data, input logic [7:0] rx,
                        input int cs_lat, input int done_lat, input bit drop);
    int c;
    bus.IN_REQ = req;
    bus.IN_REQ_DATA = data;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    bus.IN_MASTER_RECEIVE_DATA = rx;
    @(posedge clk); #1;
    o_grant = bus.OUT_GRANT; o_md0 = bus.OUT_MASTER_DATA;
    o_launch0 = bus.OUT_LAUNCH; o_busy0 = bus.OUT_BUSY;
    if (drop) begin
      bus.IN_REQ = '0;
      bus.IN_REQ_DATA = $urandom;
    end
    c = 0; o_ack_c = -1; o_lcnt = 0;
    o_ack = '0; o_to = 1'b0; o_resp = '0; o_md_end = '0; o_launch_ack = 1'b1;
    while (c < 200 && o_ack_c < 0) begin
      bus.IN_MASTER_CS = (cs_lat >= 0 && c >= cs_lat) ? 1'b0 : 1'b1;
      bus.IN_MASTER_ACTION_DONE = (cs_lat >= 0 && done_lat >= 0 && c >= cs_lat + done_lat);
      @(posedge clk); #1;
      c++;
      if (bus.OUT_ACK != '0) begin
        o_ack_c = c; o_ack = bus.OUT_ACK; o_to = bus.OUT_TIMEOUT;
        o_resp = bus.OUT_RESP_DATA; o_md_end = bus.OUT_MASTER_DATA;
        o_launch_ack = bus.OUT_LAUNCH;
      end else if (bus.OUT_LAUNCH && (cs_lat < 0 || c > cs_lat)) begin
        o_lcnt++;
      end
    end
    bus.IN_REQ = '0;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    @(posedge clk); #1;
    o_busy_after = bus.OUT_BUSY;
    o_ack_after = bus.OUT_ACK;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.IN_REQ = 4'b1111;
    bus.IN_REQ_DATA = 32'h1234_5678;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    bus.IN_MASTER_RECEIVE_DATA = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({bus.OUT_GRANT, bus.OUT_ACK, bus.OUT_TIMEOUT, bus.OUT_BUSY, bus.OUT_LAUNCH} !== 11'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {bus.OUT_GRANT, bus.OUT_ACK, bus.OUT_TIMEOUT, bus.OUT_BUSY, bus.OUT_LAUNCH}); end
    n_tests++; if (bus.OUT_MASTER_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_mdata got=%h exp=00", bus.OUT_MASTER_DATA); end
    n_tests++; if (bus.OUT_RESP_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_resp got=%h exp=00", bus.OUT_RESP_DATA); end
    rst = 1'b0;
    model_last = NR - 1;
    model_resp = '0;
    // with all requesting, the first grant after reset goes to requester 0
    @(posedge clk); #1;
    n_tests++; if (bus.OUT_GRANT !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", bus.OUT_GRANT); end
    apply_reset();
  endtask

  task automatic test_single();
    model_txn(4'b0001, 32'h0000_00EA, 8'h53, 2, 8);
    do_txn(4'b0001, 32'h0000_00EA, 8'h53, 2, 8, 1'b0);
    n_tests++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", o_grant); end
    n_tests++; if (o_launch0 !== 1'b1) begin n_fail++; $display("FAIL single_launch_latency got=%b exp=1", o_launch0); end
    n_tests++; if (o_busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", o_busy0); end
    n_tests++; if (o_md0 !== 8'hEA) begin n_fail++; $display("FAIL single_mdata got=%h exp=ea", o_md0); end
    n_tests++; if (o_lcnt !== H) begin n_fail++; $display("FAIL single_launch_hold got=%0d exp=%0d", o_lcnt, H); end
    n_tests++; if (o_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", o_ack); end
    n_tests++; if (o_ack_c !== e_ack_c) begin n_fail++; $display("FAIL single_ack_cycle got=%0d exp=%0d", o_ack_c, e_ack_c); end
    n_tests++; if (o_resp !== 8'h53) begin n_fail++; $display("FAIL single_resp got=%h exp=53", o_resp); end
    n_tests++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=%b exp=0", o_to); end
    n_tests++; if ({o_ack_after, o_busy_after} !== 5'b0) begin n_fail++; $display("FAIL single_ack_pulse got=%b exp=0", {o_ack_after, o_busy_after}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = $urandom;
      model_txn(4'b1111, d, 8'(i + 8'h30), 1, 3);
      do_txn(4'b1111, d, 8'(i + 8'h30), 1, 3, 1'b0);
      n_tests++; if (o_grant !== exp_order[i] || o_grant !== e_grant) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, o_grant, exp_order[i]); end
      n_tests++; if (o_ack !== exp_order[i]) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i, o_ack, exp_order[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] prev;
    prev = model_resp;
    model_txn(4'b0100, 32'hA5A5_A5A5, 8'h77, -1, -1);
    do_txn(4'b0100, 32'hA5A5_A5A5, 8'h77, -1, -1, 1'b0);
    n_tests++; if (o_ack_c !== T) begin n_fail++; $display("FAIL timeout_cycle got=%0d exp=%0d", o_ack_c, T); end
    n_tests++; if (o_ack !== e_grant) begin n_fail++; $display("FAIL timeout_ack got=%b exp=%b", o_ack, e_grant); end
    n_tests++; if (o_to !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got=%b exp=1", o_to); end
    n_tests++; if (o_resp !== prev) begin n_fail++; $display("FAIL timeout_resp got=%h exp=%h", o_resp, prev); end
    n_tests++; if (o_launch_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_launch_drop got=%b exp=0", o_launch_ack); end
  endtask

  task automatic test_launch_edge_ignored();
    // done rises together with CS falling: that edge is seen in LAUNCH
    model_txn(4'b1000, 32'h1100_0000, 8'h3C, 2, 0);
    do_txn(4'b1000, 32'h1100_0000, 8'h3C, 2, 0, 1'b0);
    n_tests++; if (o_to !== 1'b1 || o_ack_c !== e_ack_c) begin n_fail++; $display("FAIL launch_edge_ignored got=to%b@%0d exp=to1@%0d", o_to, o_ack_c, e_ack_c); end
    n_tests++; if (o_resp !== e_resp) begin n_fail++; $display("FAIL launch_edge_resp got=%h exp=%h", o_resp, e_resp); end
  endtask

  task automatic test_same_cycle();
    model_txn(4'b0010, 32'h0000_9900, 8'hC3, 3, T - 4);
    do_txn(4'b0010, 32'h0000_9900, 8'hC3, 3, T - 4, 1'b0);
    n_tests++; if (o_ack_c !== T) begin n_fail++; $display("FAIL same_cycle_time got=%0d exp=%0d", o_ack_c, T); end
    n_tests++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL same_cycle_timeout got=%b exp=0", o_to); end
    n_tests++; if (o_resp !== 8'hC3) begin n_fail++; $display("FAIL same_cycle_resp got=%h exp=c3", o_resp); end
    // one cycle later the done edge is too late
    model_txn(4'b0010, 32'h0000_9900, 8'h5A, 3, T - 3);
    do_txn(4'b0010, 32'h0000_9900, 8'h5A, 3, T - 3, 1'b0);
    n_tests++; if (o_to !== 1'b1 || o_resp !== e_resp) begin n_fail++; $display("FAIL late_done got=to%b resp=%h exp=to1 resp=%h", o_to, o_resp, e_resp); end
  endtask

  task automatic test_drop_req();
    model_txn(4'b0100, 32'h00D7_0000, 8'h61, 1, 2);
    do_txn(4'b0100, 32'h00D7_0000, 8'h61, 1, 2, 1'b1);
    n_tests++; if (o_md_end !== 8'hD7) begin n_fail++; $display("FAIL drop_mdata got=%h exp=d7", o_md_end); end
    n_tests++; if (o_ack !== 4'b0100) begin n_fail++; $display("FAIL drop_ack got=%b exp=0100", o_ack); end
    n_tests++; if (o_lcnt !== e_lcnt) begin n_fail++; $display("FAIL drop_hold_cut got=%0d exp=%0d", o_lcnt, e_lcnt); end
    n_tests++; if (o_resp !== 8'h61) begin n_fail++; $display("FAIL drop_resp got=%h exp=61", o_resp); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    logic       ack_seen;
    bus.IN_REQ = 4'b0100;
    bus.IN_REQ_DATA = $urandom;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    @(posedge clk); #1;
    bus.IN_MASTER_CS = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({bus.OUT_GRANT, bus.OUT_ACK, bus.OUT_TIMEOUT, bus.OUT_BUSY, bus.OUT_LAUNCH} !== 11'b0) begin n_fail++; $display("FAIL midreset_ctrl got=%b exp=0", {bus.OUT_GRANT, bus.OUT_ACK, bus.OUT_TIMEOUT, bus.OUT_BUSY, bus.OUT_LAUNCH}); end
    n_tests++; if ({bus.OUT_MASTER_DATA, bus.OUT_RESP_DATA} !== 16'h0) begin n_fail++; $display("FAIL midreset_data got=%h exp=0", {bus.OUT_MASTER_DATA, bus.OUT_RESP_DATA}); end
    rst = 1'b0;
    model_last = NR - 1;
    model_resp = '0;
    bus.IN_REQ = 4'b0010;
    seen = '0; ack_seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | bus.OUT_GRANT;
      if (bus.OUT_ACK != '0) ack_seen = 1'b1;
    end
    n_tests++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL midreset_cs_low_grant got=%b exp=0000", seen); end
    n_tests++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_ack got=%b exp=0", ack_seen); end
    bus.IN_MASTER_CS = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({bus.OUT_GRANT, bus.OUT_LAUNCH} !== 5'b0010_1) begin n_fail++; $display("FAIL midreset_regrant got=%b exp=00101", {bus.OUT_GRANT, bus.OUT_LAUNCH}); end
    apply_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  req;
      logic [31:0] d;
      logic [7:0]  rx;
      int          cs_lat, done_lat;
      bit          drop;
      req      = 4'($urandom_range(1, 15));
      d        = $urandom;
      rx       = 8'($urandom);
      cs_lat   = int'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) cs_lat = -1;
      done_lat = int'($urandom_range(1, 15));
      drop     = 1'($urandom_range(0, 1));
      model_txn(req, d, rx, cs_lat, done_lat);
      do_txn(req, d, rx, cs_lat, done_lat, drop);
      n_tests++; if (o_grant !== e_grant) begin n_fail++; $display("FAIL rand[%0d]_grant got=%b exp=%b", i, o_grant, e_grant); end
      n_tests++; if (o_md0 !== e_md || o_md_end !== e_md) begin n_fail++; $display("FAIL rand[%0d]_mdata got=%h/%h exp=%h", i, o_md0, o_md_end, e_md); end
      n_tests++; if (o_ack !== e_grant || o_ack_c !== e_ack_c) begin n_fail++; $display("FAIL rand[%0d]_ack got=%b@%0d exp=%b@%0d", i, o_ack, o_ack_c, e_grant, e_ack_c); end
      n_tests++; if (o_to !== e_to || o_resp !== e_resp) begin n_fail++; $display("FAIL rand[%0d]_resp got=to%b %h exp=to%b %h", i, o_to, o_resp, e_to, e_resp); end
      n_tests++; if (o_lcnt !== e_lcnt || o_launch_ack !== 1'b0) begin n_fail++; $display("FAIL rand[%0d]_launch got=%0d/%b exp=%0d/0", i, o_lcnt, o_launch_ack, e_lcnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.IN_REQ = '0;
    bus.IN_REQ_DATA = '0;
    bus.IN_MASTER_CS = 1'b1;
    bus.IN_MASTER_RECEIVE_DATA = '0;
    bus.IN_MASTER_ACTION_DONE = 1'b0;
    model_last = NR - 1;
    model_resp = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_launch_edge_ignored();
    test_same_cycle();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
